// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : valid/ready memory target with programmable wait states,
//            transaction counters and a sticky protocol-error flag.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LATENCY    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic                  proto_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Final wait-counter value before RESP; unused when LATENCY is 0.
    localparam logic [3:0] LAST_WAIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   ready_q, ready_d;
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        rd_data_d  = rd_data_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_d      = err_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    addr_d     = addr_i;
                    wr_d       = wr_rd_i;
                    data_d     = wr_data_i;
                    wait_cnt_d = 4'd0;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else begin
                        // Zero wait states: fields are captured this edge, so use them directly.
                        state_d = RESP;
                        ready_d = 1'b1;
                        if (!wr_rd_i) begin
                            rd_data_d = mem_q[addr_i];
                        end
                    end
                end
            end
            WAIT: begin
                if (!valid_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!wr_q) begin
                        rd_data_d = mem_q[addr_q];
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (valid_i) begin
                    if (wr_q) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            rd_data_q  <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_q      <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            rd_data_q  <= rd_data_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            err_q      <= err_d;
            if (mem_we) begin
                mem_q[addr_q] <= data_q;
            end
        end
    end

    assign ready_o     = ready_q;
    assign rd_data_o   = rd_data_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign proto_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : scoreboard bench for mem_responder at LATENCY 0 and LATENCY 3.
// Revision : 1.0
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid [2];
    logic        wr    [2];
    logic [5:0]  addr  [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic [15:0] rdata [2];
    logic [15:0] wcnt  [2];
    logic [15:0] rcnt  [2];
    logic        err   [2];

    logic [15:0] model [2][64];
    logic [15:0] exp_q [$];
    int          exp_wr [2];
    int          exp_rd [2];
    int          last_cap [2];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.WIDTH(16), .DEPTH(64), .LATENCY(0), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .rst(rst), .valid_i(valid[0]), .wr_rd_i(wr[0]), .addr_i(addr[0]),
        .wr_data_i(wdata[0]), .ready_o(ready[0]), .rd_data_o(rdata[0]),
        .wr_cnt_o(wcnt[0]), .rd_cnt_o(rcnt[0]), .proto_err_o(err[0])
    );

    mem_responder #(.WIDTH(16), .DEPTH(64), .LATENCY(3), .CNT_WIDTH(16)) u_dut3 (
        .clk(clk), .rst(rst), .valid_i(valid[1]), .wr_rd_i(wr[1]), .addr_i(addr[1]),
        .wr_data_i(wdata[1]), .ready_o(ready[1]), .rd_data_o(rdata[1]),
        .wr_cnt_o(wcnt[1]), .rd_cnt_o(rcnt[1]), .proto_err_o(err[1])
    );

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) model[s][i] = 16'h0;
            exp_wr[s] = 0;
            exp_rd[s] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
    endtask

    task automatic check_counts(input int s);
        check("wr_cnt", wcnt[s], exp_wr[s]);
        check("rd_cnt", rcnt[s], exp_rd[s]);
    endtask

    // One complete handshake; chain=1 also checks spacing from the previous capture.
    task automatic txn(input int s, input bit w, input int a, input logic [15:0] d,
                       input bit chg, input bit chain);
        int lat;
        int cap;
        bit seen;
        logic [15:0] e;
        @(negedge clk);
        valid[s] = 1'b1; wr[s] = w; addr[s] = 6'(a); wdata[s] = d;
        if (!w) exp_q.push_back(model[s][a]);
        @(posedge clk);
        #1 cap = cyc;
        if (chg) begin
            addr[s] = 6'(a + 1);
            wdata[s] = ~d;
        end
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = ready[s];
        end
        check("latency", lat, lat_of(s) + 1);
        if (!w) begin
            e = exp_q.pop_front();
            if (seen) check("rd_data", rdata[s], e);
        end
        @(posedge clk);
        if (seen) begin
            if (w) begin
                model[s][a] = d;
                exp_wr[s]++;
            end else begin
                exp_rd[s]++;
            end
        end
        #1 valid[s] = 1'b0;
        check("ready_pulse", ready[s], 1'b0);
        if (chain) check("spacing", cap - last_cap[s], lat_of(s) + 2);
        last_cap[s] = cap;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
            last_cap[s] = 0;
        end
        do_reset();

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", ready[s], 1'b0);
            check("rst_rdata", rdata[s], 16'h0);
            check_counts(s);
            check("rst_err", err[s], 1'b0);
        end
        txn(0, 1'b0, 5, 16'h0, 1'b0, 1'b0);

        for (int i = 0; i < 64; i++) txn(0, 1'b1, i, 16'hA000 + 16'(i), 1'b0, i > 0);
        for (int i = 0; i < 64; i++) txn(0, 1'b0, i, 16'h0, 1'b0, 1'b1);
        check_counts(0);

        // Address changes after capture must not redirect the read.
        txn(0, 1'b0, 3, 16'h0, 1'b1, 1'b0);
        check("addr_chg_err", err[0], 1'b0);

        txn(1, 1'b1, 10, 16'h1234, 1'b0, 1'b0);
        txn(1, 1'b0, 10, 16'h0, 1'b0, 1'b1);
        check_counts(1);

        // Abandon a read after one wait cycle.
        @(negedge clk);
        valid[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'd7;
        @(posedge clk);
        @(posedge clk);
        #1 valid[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ready[1];
        end
        check("drop_no_ready", seen, 1'b0);
        check("drop_err", err[1], 1'b1);
        check_counts(1);
        txn(1, 1'b0, 7, 16'h0, 1'b0, 1'b0);
        check("err_sticky", err[1], 1'b1);
        check_counts(1);

        // Reset lands while a write is waiting.
        @(negedge clk);
        valid[1] = 1'b1; wr[1] = 1'b1; addr[1] = 6'd20; wdata[1] = 16'hBEEF;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | ready[1];
        end
        valid[1] = 1'b0;
        #1 rst = 1'b1;
        clear_model();
        @(negedge clk);
        seen = seen | ready[1];
        check("rst_wait_ready", seen, 1'b0);
        check_counts(1);
        check("rst_wait_err", err[1], 1'b0);
        txn(1, 1'b0, 20, 16'h0, 1'b0, 1'b0);
        check_counts(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target (responder) side of the team's valid/ready single-port memory access protocol.
- Accepts write and read requests from an initiator (bench driver or bus master), inserts a programmable number of wait states, then acknowledges with a one-cycle ready_o pulse.
- Holds DEPTH x WIDTH storage, returns read data alongside ready_o, keeps transaction counters and a sticky protocol-error flag for checking.

Parameters:
- WIDTH, 16: data width in bits
- DEPTH, 64: number of memory locations
- ADDR_WIDTH, $clog2(DEPTH): address width
- LATENCY, 0: wait-state cycles inserted before ready_o (0..15)
- CNT_WIDTH, 16: width of the transaction counters

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- valid_i  in  1  request valid; held high with fields stable until ready_o sampled high
- wr_rd_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  request address
- wr_data_i  in  WIDTH  write data
- ready_o  out  1  one-cycle acknowledge; the transaction completes on the edge where valid_i and ready_o are both 1
- rd_data_o  out  WIDTH  read data, valid while ready_o is high for a read; holds until the next read
- wr_cnt_o  out  CNT_WIDTH  completed writes
- rd_cnt_o  out  CNT_WIDTH  completed reads
- proto_err_o  out  1  sticky: valid_i dropped before acknowledge

Behaviour:
- Reset (rst = 0 at a rising edge):
  - State goes to IDLE.
  - ready_o, rd_data_o, wr_cnt_o, rd_cnt_o and proto_err_o go to 0.
  - All memory locations are cleared to 0.
  - Reset has priority over every other event.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When valid_i = 1 at an edge, capture addr_i, wr_rd_i and wr_data_i.
  - Load the wait counter with 0.
  - Go to WAIT if LATENCY > 0, otherwise go to RESP.
- WAIT:
  - The wait counter increments every cycle.
  - When it reaches LATENCY-1, go to RESP.
  - If valid_i = 0 at any edge in WAIT: set proto_err_o, discard the request (no write, no counter change), go to IDLE.
- Entry to RESP (registered outputs):
  - ready_o is set to 1.
  - For a read, rd_data_o is loaded with mem[captured addr].
  - For a write, rd_data_o is unchanged.
- RESP:
  - Lasts exactly one cycle, then the FSM goes to IDLE unconditionally.
  - On the RESP->IDLE edge: a write commits mem[addr] <= data and increments wr_cnt_o; a read increments rd_cnt_o. ready_o returns to 0.
  - If valid_i = 0 on that edge: set proto_err_o, no commit, no count.
- Latency: ready_o goes high LATENCY+1 cycles after the edge at which valid_i is first sampled in IDLE.
- Throughput: one transaction per LATENCY+2 cycles. Back-to-back requests are accepted from IDLE at the edge after RESP.
- The captured fields are used throughout. Changes on addr_i or wr_data_i after capture are ignored; they are not errors.
- Read-after-write to the same address returns the newly written data, because the write commits before the next capture.
- Counters wrap modulo 2^CNT_WIDTH.
- proto_err_o clears only on reset.
- Reset during WAIT or RESP:
  - Any pending write is discarded and ready_o drops at that edge.
  - Memory and counters are cleared.

Test Plan:
- Reset with LATENCY=0: hold rst=0 for 2 edges -> ready_o=0, rd_data_o=0, counters=0, proto_err_o=0; a read of addr 5 returns 0.
- LATENCY=0, write addr 0..63 with data 16'hA000+addr, then read 0..63 -> each read returns 16'hA000+addr in the ready_o cycle; each ready_o is 1 cycle after valid_i is sampled; wr_cnt_o=64, rd_cnt_o=64.
- LATENCY=3: write 16'h1234 to addr 10, then read addr 10 -> ready_o high exactly 4 cycles after valid_i is sampled, for 1 cycle; rd_data_o=16'h1234; each transaction occupies 5 cycles.
- LATENCY=3: read addr 7, drop valid_i after 1 wait cycle -> proto_err_o=1 and stays 1; no ready_o pulse; rd_cnt_o unchanged; a following valid read completes normally.
- LATENCY=3: write 16'hBEEF to addr 20, assert rst=0 mid-WAIT -> ready_o stays 0, counters=0; after reset, a read of addr 20 returns 0.
- LATENCY=0: change addr_i from 3 to 4 while a read of addr 3 is pending -> data from addr 3 is returned; proto_err_o stays 0.
